// File: rtl/crc_buffer_reader.sv
// Read-side controller for the CRC fingerprint buffer RAM: issues sequential reads for
// committed entries and streams them through a 2-entry skid FIFO toward the comparator.
module crc_buffer_reader #(
  parameter int CW = 32,
  parameter int RW = 5,
  parameter int RS = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          commit,
  output logic [RW-1:0] rd_addr,
  input  logic [CW-1:0] ram_rdata,
  output logic [CW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW:0]   occupancy,
  output logic [RW:0]   free_slots,
  output logic          overflow
);

  localparam logic [RW:0]   RS_C      = (RW+1)'(RS);
  localparam logic [RW:0]   CNT_ONE_C = {{RW{1'b0}}, 1'b1};
  localparam logic [RW-1:0] LAST_C    = RW'(RS - 1);
  localparam logic [RW-1:0] PTR_ONE_C = {{(RW-1){1'b0}}, 1'b1};

  logic [RW-1:0] rd_ptr_r;
  logic [RW:0]   pending_r;
  logic [RW:0]   occ_r;
  logic [RW:0]   free_r;
  logic          inflight_r;
  logic [CW-1:0] skid0_r;
  logic [CW-1:0] skid1_r;
  logic [1:0]    skid_cnt_r;
  logic          out_valid_r;
  logic          overflow_r;

  logic          xfer_s;
  logic          full_s;
  logic          commit_ok_s;
  logic          ovf_hit_s;
  logic [1:0]    cnt_after_s;
  logic          issue_s;
  logic [RW:0]   occ_nxt_s;
  logic [RW:0]   pend_nxt_s;
  logic [RW-1:0] ptr_nxt_s;
  logic [CW-1:0] s0_nxt_s;
  logic [CW-1:0] s1_nxt_s;
  logic [1:0]    cnt_nxt_s;

  // Next-state decode: issue counts the skid slot freed by this cycle's transfer so
  // a continuously ready consumer sees one entry per clock.
  always_comb begin
    xfer_s      = out_valid_r && out_ready;
    full_s      = (occ_r == RS_C);
    commit_ok_s = commit && (!full_s || xfer_s);
    ovf_hit_s   = commit && full_s && !xfer_s;
    cnt_after_s = skid_cnt_r - {1'b0, xfer_s};
    issue_s     = (pending_r != {(RW+1){1'b0}}) &&
                  (({1'b0, inflight_r} + cnt_after_s) < 2'd2);

    case ({commit_ok_s, xfer_s})
      2'b10:   occ_nxt_s = occ_r + CNT_ONE_C;
      2'b01:   occ_nxt_s = occ_r - CNT_ONE_C;
      default: occ_nxt_s = occ_r;
    endcase

    case ({commit_ok_s, issue_s})
      2'b10:   pend_nxt_s = pending_r + CNT_ONE_C;
      2'b01:   pend_nxt_s = pending_r - CNT_ONE_C;
      default: pend_nxt_s = pending_r;
    endcase

    if (!issue_s) begin
      ptr_nxt_s = rd_ptr_r;
    end else if (rd_ptr_r == LAST_C) begin
      ptr_nxt_s = {RW{1'b0}};
    end else begin
      ptr_nxt_s = rd_ptr_r + PTR_ONE_C;
    end

    // Pop shifts slot 1 to the head; the returning RAM word lands in the first free slot.
    s0_nxt_s  = (inflight_r && cnt_after_s == 2'd0) ? ram_rdata :
                (xfer_s ? skid1_r : skid0_r);
    s1_nxt_s  = (inflight_r && cnt_after_s != 2'd0) ? ram_rdata : skid1_r;
    cnt_nxt_s = cnt_after_s + {1'b0, inflight_r};
  end

  // State registers; flush clears everything including data still returning from the RAM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_r    <= {RW{1'b0}};
      pending_r   <= {(RW+1){1'b0}};
      occ_r       <= {(RW+1){1'b0}};
      free_r      <= RS_C;
      inflight_r  <= 1'b0;
      skid0_r     <= {CW{1'b0}};
      skid1_r     <= {CW{1'b0}};
      skid_cnt_r  <= 2'd0;
      out_valid_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else if (flush) begin
      rd_ptr_r    <= {RW{1'b0}};
      pending_r   <= {(RW+1){1'b0}};
      occ_r       <= {(RW+1){1'b0}};
      free_r      <= RS_C;
      inflight_r  <= 1'b0;
      skid0_r     <= {CW{1'b0}};
      skid1_r     <= {CW{1'b0}};
      skid_cnt_r  <= 2'd0;
      out_valid_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      rd_ptr_r    <= ptr_nxt_s;
      pending_r   <= pend_nxt_s;
      occ_r       <= occ_nxt_s;
      free_r      <= RS_C - occ_nxt_s;
      inflight_r  <= issue_s;
      skid0_r     <= s0_nxt_s;
      skid1_r     <= s1_nxt_s;
      skid_cnt_r  <= cnt_nxt_s;
      out_valid_r <= (cnt_nxt_s != 2'd0);
      overflow_r  <= overflow_r | ovf_hit_s;
    end
  end

  assign rd_addr    = rd_ptr_r;
  assign out_data   = skid0_r;
  assign out_valid  = out_valid_r;
  assign occupancy  = occ_r;
  assign free_slots = free_r;
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_crc_buffer_reader.sv
// Self-checking bench for crc_buffer_reader: a RAM model plus a queue-based reference
// of committed entries, occupancy and overflow, driven with randomized stimulus.
module tb_crc_buffer_reader;
  localparam int CW = 32;
  localparam int RW = 5;
  localparam int RS = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          flush = 1'b0;
  logic          commit = 1'b0;
  logic          out_ready = 1'b0;
  logic [RW-1:0] rd_addr;
  logic [CW-1:0] ram_rdata;
  logic [CW-1:0] out_data;
  logic          out_valid;
  logic [RW:0]   occupancy;
  logic [RW:0]   free_slots;
  logic          overflow;

  crc_buffer_reader #(.CW(CW), .RW(RW), .RS(RS)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .commit(commit),
    .rd_addr(rd_addr), .ram_rdata(ram_rdata), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .occupancy(occupancy),
    .free_slots(free_slots), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // RAM: registered read address, combinational data out, writer port
  logic [CW-1:0] mem [RS];
  logic [RW-1:0] addr_q;
  logic          we = 1'b0;
  logic [RW-1:0] waddr = '0;
  logic [CW-1:0] wdata = '0;
  always @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    addr_q <= rd_addr;
  end
  assign ram_rdata = mem[addr_q];

  // reference model
  logic [CW-1:0] exp_q[$];
  int            occ_m = 0;
  bit            ovf_m = 1'b0;
  int            wr_m = 0;
  int            n_cmp = 0;
  int            n_err = 0;
  int            n_issue = 0;
  logic [RW-1:0] prev_addr = '0;

  task automatic model_clear();
    exp_q.delete();
    occ_m = 0; ovf_m = 1'b0; wr_m = 0; n_issue = 0; prev_addr = '0;
  endtask

  // one clock: inputs set after negedge, checks 1 time unit after the posedge
  task automatic cycle(input bit c, input logic [CW-1:0] d, input bit rdy, input bit fl);
    bit xfer, acc, hold;
    logic [CW-1:0] held;
    int nx;
    @(negedge clk);
    commit = c; out_ready = rdy; flush = fl;
    xfer = out_valid && rdy && !fl;
    acc  = c && !fl && (occ_m < RS || xfer);
    we = acc; waddr = RW'(wr_m); wdata = d;
    if (xfer) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++; $display("FAIL stream_data: got %h with no entry expected", out_data);
      end else if (out_data !== exp_q[0]) begin
        n_err++; $display("FAIL stream_data: got %h expected %h", out_data, exp_q[0]);
      end
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    if (fl) begin
      exp_q.delete(); occ_m = 0; ovf_m = 1'b0; wr_m = 0;
    end else begin
      if (c && !acc) ovf_m = 1'b1;
      if (acc) begin exp_q.push_back(d); wr_m = (wr_m + 1) % RS; end
      occ_m = occ_m + int'(acc) - int'(xfer);
    end
    hold = out_valid && !rdy && !fl;
    held = out_data;
    @(posedge clk); #1;
    commit = 1'b0; flush = 1'b0; we = 1'b0;
    n_cmp++;
    if (occupancy !== (RW+1)'(occ_m)) begin
      n_err++; $display("FAIL occupancy: got %0d expected %0d", occupancy, occ_m);
    end
    n_cmp++;
    if (free_slots !== (RW+1)'(RS - occ_m)) begin
      n_err++; $display("FAIL free_slots: got %0d expected %0d", free_slots, RS - occ_m);
    end
    n_cmp++;
    if (overflow !== ovf_m) begin
      n_err++; $display("FAIL overflow: got %b expected %b", overflow, ovf_m);
    end
    n_cmp++;
    if (out_valid && exp_q.size() == 0) begin
      n_err++; $display("FAIL spurious_valid: out_valid=1 with data %h, nothing pending", out_data);
    end
    if (hold) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== held) begin
        n_err++; $display("FAIL hold_stable: got valid=%b data=%h expected 1 %h", out_valid, out_data, held);
      end
    end
    if (fl) begin
      n_issue = 0;
    end else if (rd_addr !== prev_addr) begin
      n_issue++;
      nx = (int'(prev_addr) + 1) % RS;
      n_cmp++;
      if (rd_addr !== RW'(nx)) begin
        n_err++; $display("FAIL rd_addr_step: got %0d expected %0d", rd_addr, nx);
      end
    end
    prev_addr = rd_addr;
  endtask

  task automatic drain(input int budget);
    for (int k = 0; k < budget && (exp_q.size() != 0 || out_valid); k++) cycle(1'b0, '0, 1'b1, 1'b0);
    n_cmp++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL drain: %0d entries left, out_valid=%b expected 0 left", exp_q.size(), out_valid);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== '0 || occupancy !== '0 || free_slots !== (RW+1)'(RS)
        || overflow !== 1'b0 || rd_addr !== '0) begin
      n_err++;
      $display("FAIL reset_state: got v=%b d=%h occ=%0d free=%0d ovf=%b addr=%0d expected 0 0 0 %0d 0 0",
               out_valid, out_data, occupancy, free_slots, overflow, rd_addr, RS);
    end
    @(negedge clk); reset_n = 1'b1;
    model_clear();
  endtask

  task automatic test_latency();
    cycle(1'b1, 32'hA0, 1'b1, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b0 || rd_addr !== '0) begin
      n_err++; $display("FAIL lat_c1: got valid=%b addr=%0d expected 0 0", out_valid, rd_addr);
    end
    cycle(1'b1, 32'hA1, 1'b1, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL lat_c2: got valid=%b expected 0", out_valid);
    end
    cycle(1'b1, 32'hA2, 1'b1, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 32'hA0) begin
      n_err++; $display("FAIL lat_c3: got valid=%b data=%h expected 1 a0", out_valid, out_data);
    end
    for (int k = 4; k <= 5; k++) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      n_cmp++;
      if (out_valid !== 1'b1) begin
        n_err++; $display("FAIL lat_back_to_back c%0d: got valid=%b expected 1", k, out_valid);
      end
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b0 || occupancy !== '0) begin
      n_err++; $display("FAIL lat_done: got valid=%b occ=%0d expected 0 0", out_valid, occupancy);
    end
  endtask

  task automatic test_backpressure();
    cycle(1'b0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) cycle(1'b1, $urandom, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) cycle(1'b0, '0, 1'b0, 1'b0);
    n_cmp++;
    if (rd_addr !== RW'(2) || occupancy !== (RW+1)'(4) || free_slots !== (RW+1)'(RS - 4)) begin
      n_err++; $display("FAIL backpressure: got addr=%0d occ=%0d free=%0d expected 2 4 %0d",
                        rd_addr, occupancy, free_slots, RS - 4);
    end
    drain(20);
  endtask

  task automatic test_wrap();
    cycle(1'b0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 40; k++) cycle(1'b1, $urandom, ($urandom_range(0, 3) != 0), 1'b0);
    drain(100);
    n_cmp++;
    if (n_issue != 40 || rd_addr !== RW'(8)) begin
      n_err++; $display("FAIL wrap: got issues=%0d addr=%0d expected 40 8", n_issue, rd_addr);
    end
  endtask

  task automatic test_overflow();
    cycle(1'b0, '0, 1'b0, 1'b1);
    for (int k = 0; k < RS; k++) cycle(1'b1, $urandom, 1'b0, 1'b0);
    cycle(1'b1, $urandom, 1'b0, 1'b0);
    n_cmp++;
    if (overflow !== 1'b1 || occupancy !== (RW+1)'(RS)) begin
      n_err++; $display("FAIL overflow_set: got ovf=%b occ=%0d expected 1 %0d", overflow, occupancy, RS);
    end
    cycle(1'b0, '0, 1'b0, 1'b1);
    for (int k = 0; k < RS; k++) cycle(1'b1, $urandom, 1'b0, 1'b0);
    cycle(1'b1, $urandom, 1'b1, 1'b0);
    n_cmp++;
    if (overflow !== 1'b0 || occupancy !== (RW+1)'(RS)) begin
      n_err++; $display("FAIL full_commit_xfer: got ovf=%b occ=%0d expected 0 %0d", overflow, occupancy, RS);
    end
    drain(200);
  endtask

  task automatic test_flush();
    cycle(1'b1, $urandom, 1'b0, 1'b0);
    cycle(1'b1, $urandom, 1'b0, 1'b0);
    cycle(1'b1, $urandom, 1'b0, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_err++; $display("FAIL flush_setup: got valid=%b expected 1", out_valid);
    end
    cycle(1'b1, $urandom, 1'b1, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b0 || occupancy !== '0 || rd_addr !== '0 || overflow !== 1'b0) begin
      n_err++; $display("FAIL flush_clear: got v=%b occ=%0d addr=%0d ovf=%b expected 0 0 0 0",
                        out_valid, occupancy, rd_addr, overflow);
    end
    for (int k = 0; k < 4; k++) cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b1, $urandom, 1'b1, 1'b0);
    drain(10);
  endtask

  task automatic test_reset_midstream();
    for (int k = 0; k < 3; k++) cycle(1'b1, $urandom, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      n_err++; $display("FAIL async_reset: got valid=%b data=%h expected 0 0", out_valid, out_data);
    end
    model_clear();
    @(negedge clk); @(negedge clk); reset_n = 1'b1;
    cycle(1'b1, $urandom, 1'b1, 1'b0);
    n_cmp++;
    if (rd_addr !== '0) begin
      n_err++; $display("FAIL reset_first_addr: got %0d expected 0", rd_addr);
    end
    drain(10);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_backpressure();
    test_wrap();
    test_overflow();
    test_flush();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

endmodule

// File: doc/crc_buffer_reader.md
Name: crc_buffer_reader

Overview:
- Read-side controller for the CRC fingerprint buffer RAM (registered read address, combinational data out, one-cycle read latency).
- Tracks entries committed by the writer and issues sequential reads with wrap-around.
- Absorbs the RAM read latency and presents entries on a valid/ready stream toward the fingerprint comparator.
- Reports occupancy and free slots so the writer can throttle, and flags overflow.

Parameters:
CW, 32, CRC entry width (matches buffer CRC width)
RW, 5, RAM address width
RS, 32, RAM depth in entries; 2 <= RS <= 2**RW; need not be a power of two

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of all pointers, counters, buffered data and overflow
commit  input  1  writer pulse: one new entry written at the writer's next sequential slot; may coincide with the RAM write_en cycle
rd_addr  output  RW  read address to RAM addr_r; equals rd_ptr combinationally
ram_rdata  input  CW  RAM data_out; valid the cycle after rd_addr is presented
out_data  output  CW  head entry of the output stream
out_valid  output  1  out_data holds a valid entry
out_ready  input  1  consumer accepts; a transfer occurs when out_valid && out_ready
occupancy  output  RW+1  committed entries not yet consumed
free_slots  output  RW+1  RS - occupancy
overflow  output  1  sticky: commit seen while occupancy == RS

Behaviour:
- Reset (async, reset_n low): rd_ptr=0, occupancy=0, pending=0, inflight=0, skid empty, out_valid=0, out_data=0, overflow=0.
- pending (internal) = committed entries not yet issued to the RAM.
  - +1 on commit, -1 on issue; both in the same cycle leaves it unchanged.
- issue = (pending != 0) && (inflight + skid_count < 2).
  - Issuing advances rd_ptr at the clock edge: RS-1 wraps to 0.
  - inflight <= issue (registered). The following cycle, ram_rdata is pushed into the 2-entry output skid buffer.
- Output skid buffer is a FIFO: out_data/out_valid reflect its head.
  - out_data is registered.
  - Throughput is 1 entry/clk while out_ready is held high.
  - An issued read is never cancelled; the issue condition guarantees space for it.
- Latency: commit in cycle 0 -> issue in cycle 1 -> ram_rdata valid in cycle 2 -> out_valid high in cycle 3.
- Read-after-write safety: commit may share the cycle of the RAM write. The earliest read address is registered one edge later, so new data is always returned.
- occupancy:
  - +1 on commit, -1 on transfer; simultaneous commit and transfer leaves it unchanged.
  - Saturates at RS.
  - Commit at occupancy == RS without a same-cycle transfer: sets overflow; pending and occupancy do not change.
- Underflow is impossible: transfers require out_valid.
- flush has priority over commit/issue/transfer in the same cycle.
  - Returns all state to reset values.
  - Discards in-flight RAM data.
- While out_valid=1 and out_ready=0: out_data is held stable.
- Reset asserted mid-stream: outputs drop immediately (async); no partial entry survives.

Test Plan:
- Commit 3 entries in consecutive cycles (RAM holds 0xA0..0xA2), out_ready=1 -> out_valid first high in cycle 3; data 0xA0, 0xA1, 0xA2 on consecutive cycles; occupancy returns to 0.
- Commit 4 entries, out_ready=0 -> exactly 2 reads issued, out_data=first entry held stable, occupancy=4, free_slots=RS-4; raise out_ready -> remaining entries stream in order with no loss or duplication.
- Wrap-around (RS=32): commit and consume 40 entries -> rd_addr sequence 0..31,0..7; data matches RAM contents at each address.
- Fill to occupancy=32 with out_ready=0, then one more commit -> overflow=1, occupancy stays 32; commit together with a transfer at 32 -> no overflow, occupancy 32.
- flush asserted while a read is in flight and out_valid=1 -> next cycle out_valid=0, occupancy=0, rd_addr=0, overflow=0; no stale entry appears afterwards.
- reset_n pulsed low mid-stream, asynchronously between clock edges -> out_valid=0 and out_data=0 immediately; after release, the first committed entry is read from address 0.
